l1_sram_dp_ctrl: RTL and testbench

- Initiator-side controller for the L1 256x32b dual-port SRAM.
- Accepts two independent valid/ready request channels (c0, c1) and drives the SRAM pins: shared active-low cen, per-port byte write enable, addr, wdata.
- Captures read data, which arrives one cycle after issue, into per-channel response FIFOs with backpressure.
- Resolves same-address port conflicts that the macro does not handle.

---
 rtl/l1_sram_ctrl_pkg.sv | 18 +
 rtl/l1_sram_rsp_fifo.sv | 61 ++++++
 rtl/l1_sram_dp_ctrl.sv | 161 ++++++++++++++++
 tb/tb_l1_sram_dp_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_sram_ctrl_pkg.sv
// rtl/l1_sram_ctrl_pkg.sv - shared widths, request type and helpers for the L1 dual-port SRAM controller
package l1_sram_ctrl_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 32;
    localparam int NB_DEF = DW_DEF / 8;

    typedef struct packed {
        logic [AW_DEF-1:0] addr;
        logic [NB_DEF-1:0] wstrb;
        logic [DW_DEF-1:0] wdata;
    } req_t;

    function automatic logic is_write(input logic [NB_DEF-1:0] wstrb);
        return |wstrb;
    endfunction

endpackage

// File: rtl/l1_sram_rsp_fifo.sv
// rtl/l1_sram_rsp_fifo.sv - synchronous read-response FIFO, one per channel
module l1_sram_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int DW    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [DW-1:0]          push_data,
    input  logic                   pop,
    output logic [DW-1:0]          pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign pop_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && full));

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && empty));

endmodule

// File: rtl/l1_sram_dp_ctrl.sv
// rtl/l1_sram_dp_ctrl.sv - dual-channel initiator for the L1 256x32 dual-port SRAM (optional L1_SRAM_CTRL_STATS_EN counters)
module l1_sram_dp_ctrl
    import l1_sram_ctrl_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int NB        = DW / 8,
    parameter int RSP_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          c0_req_valid,
    output logic          c0_req_ready,
    input  logic [AW-1:0] c0_req_addr,
    input  logic [NB-1:0] c0_req_wstrb,
    input  logic [DW-1:0] c0_req_wdata,
    output logic          c0_rsp_valid,
    input  logic          c0_rsp_ready,
    output logic [DW-1:0] c0_rsp_rdata,

    input  logic          c1_req_valid,
    output logic          c1_req_ready,
    input  logic [AW-1:0] c1_req_addr,
    input  logic [NB-1:0] c1_req_wstrb,
    input  logic [DW-1:0] c1_req_wdata,
    output logic          c1_rsp_valid,
    input  logic          c1_rsp_ready,
    output logic [DW-1:0] c1_rsp_rdata,

    output logic          sram_cen,
    output logic [NB-1:0] sram_wea0,
    output logic [AW-1:0] sram_addr0,
    output logic [DW-1:0] sram_wdata0,
    input  logic [DW-1:0] sram_rdata0,
    output logic [NB-1:0] sram_wea1,
    output logic [AW-1:0] sram_addr1,
    output logic [DW-1:0] sram_wdata1,
    input  logic [DW-1:0] sram_rdata1
`ifdef L1_SRAM_CTRL_STATS_EN
    ,
    output logic [31:0]   stat_rd_cnt,
    output logic [31:0]   stat_wr_cnt,
    output logic [31:0]   stat_stall_cnt
`endif
);

    localparam int CW = $clog2(RSP_DEPTH) + 1;

    logic          wr0;
    logic          wr1;
    logic          credit0;
    logic          credit1;
    logic          same_addr_ww;
    logic          fire0;
    logic          fire1;
    logic          inflight0;
    logic          inflight1;
    logic [CW-1:0] count0;
    logic [CW-1:0] count1;
    logic          empty0;
    logic          empty1;

    assign wr0 = is_write(c0_req_wstrb);
    assign wr1 = is_write(c1_req_wstrb);

    // A read reserves its FIFO slot at issue; the slot freed by a same-cycle pop is not reused yet
    assign credit0 = (CW'(inflight0) + count0) < CW'(RSP_DEPTH);
    assign credit1 = (CW'(inflight1) + count1) < CW'(RSP_DEPTH);

    // Two writes to one word would collide inside the macro: c0 goes first, c1 waits a cycle
    assign same_addr_ww = c0_req_valid & wr0 & wr1 & (c0_req_addr == c1_req_addr);

    assign c0_req_ready = rst_n & (wr0 | credit0);
    assign c1_req_ready = rst_n & (wr1 | credit1) & ~same_addr_ww;

    assign fire0 = c0_req_valid & c0_req_ready;
    assign fire1 = c1_req_valid & c1_req_ready;

    assign sram_cen    = ~(fire0 | fire1);
    assign sram_wea0   = fire0 ? c0_req_wstrb : '0;
    assign sram_wea1   = fire1 ? c1_req_wstrb : '0;
    assign sram_addr0  = c0_req_addr;
    assign sram_addr1  = c1_req_addr;
    assign sram_wdata0 = c0_req_wdata;
    assign sram_wdata1 = c1_req_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight0 <= 1'b0;
            inflight1 <= 1'b0;
        end else begin
            inflight0 <= fire0 & ~wr0;
            inflight1 <= fire1 & ~wr1;
        end
    end

    // Read data is on the macro pins the cycle after issue; capture it straight into the FIFO
    l1_sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .DW    (DW)
    ) u_rsp_fifo0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight0),
        .push_data (sram_rdata0),
        .pop       (c0_rsp_valid & c0_rsp_ready),
        .pop_data  (c0_rsp_rdata),
        .count     (count0),
        .empty     (empty0)
    );

    l1_sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .DW    (DW)
    ) u_rsp_fifo1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight1),
        .push_data (sram_rdata1),
        .pop       (c1_rsp_valid & c1_rsp_ready),
        .pop_data  (c1_rsp_rdata),
        .count     (count1),
        .empty     (empty1)
    );

    assign c0_rsp_valid = ~empty0;
    assign c1_rsp_valid = ~empty1;

    a_no_ww_collision: assert property (@(posedge clk) disable iff (!rst_n)
        !(fire0 && fire1 && wr0 && wr1 && (c0_req_addr == c1_req_addr)));

`ifdef L1_SRAM_CTRL_STATS_EN
    logic [1:0] rd_inc;
    logic [1:0] wr_inc;
    logic       stall;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] inc);
        logic [32:0] s;
        s = {1'b0, a} + {31'b0, inc};
        return s[32] ? '1 : s[31:0];
    endfunction

    assign rd_inc = {1'b0, fire0 & ~wr0} + {1'b0, fire1 & ~wr1};
    assign wr_inc = {1'b0, fire0 &  wr0} + {1'b0, fire1 &  wr1};
    assign stall  = (c0_req_valid & ~c0_req_ready) | (c1_req_valid & ~c1_req_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_rd_cnt    <= '0;
            stat_wr_cnt    <= '0;
            stat_stall_cnt <= '0;
        end else begin
            stat_rd_cnt    <= sat_add(stat_rd_cnt, rd_inc);
            stat_wr_cnt    <= sat_add(stat_wr_cnt, wr_inc);
            stat_stall_cnt <= sat_add(stat_stall_cnt, {1'b0, stall});
        end
    end
`endif

endmodule

// File: tb/tb_l1_sram_dp_ctrl.sv
// tb/tb_l1_sram_dp_ctrl.sv - self-checking bench for l1_sram_dp_ctrl with a request-level reference model
module tb_l1_sram_dp_ctrl;
    import l1_sram_ctrl_pkg::*;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        c0_req_valid, c0_req_ready, c0_rsp_valid, c0_rsp_ready;
    logic [7:0]  c0_req_addr;
    logic [3:0]  c0_req_wstrb;
    logic [31:0] c0_req_wdata, c0_rsp_rdata;
    logic        c1_req_valid, c1_req_ready, c1_rsp_valid, c1_rsp_ready;
    logic [7:0]  c1_req_addr;
    logic [3:0]  c1_req_wstrb;
    logic [31:0] c1_req_wdata, c1_rsp_rdata;
    logic        sram_cen;
    logic [3:0]  sram_wea0, sram_wea1;
    logic [7:0]  sram_addr0, sram_addr1;
    logic [31:0] sram_wdata0, sram_wdata1, sram_rdata0, sram_rdata1;
`ifdef L1_SRAM_CTRL_STATS_EN
    logic [31:0] stat_rd_cnt, stat_wr_cnt, stat_stall_cnt;
`endif

    l1_sram_dp_ctrl #(.RSP_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .c0_req_valid(c0_req_valid), .c0_req_ready(c0_req_ready), .c0_req_addr(c0_req_addr),
        .c0_req_wstrb(c0_req_wstrb), .c0_req_wdata(c0_req_wdata), .c0_rsp_valid(c0_rsp_valid),
        .c0_rsp_ready(c0_rsp_ready), .c0_rsp_rdata(c0_rsp_rdata),
        .c1_req_valid(c1_req_valid), .c1_req_ready(c1_req_ready), .c1_req_addr(c1_req_addr),
        .c1_req_wstrb(c1_req_wstrb), .c1_req_wdata(c1_req_wdata), .c1_rsp_valid(c1_rsp_valid),
        .c1_rsp_ready(c1_rsp_ready), .c1_rsp_rdata(c1_rsp_rdata),
        .sram_cen(sram_cen),
        .sram_wea0(sram_wea0), .sram_addr0(sram_addr0), .sram_wdata0(sram_wdata0), .sram_rdata0(sram_rdata0),
        .sram_wea1(sram_wea1), .sram_addr1(sram_addr1), .sram_wdata1(sram_wdata1), .sram_rdata1(sram_rdata1)
`ifdef L1_SRAM_CTRL_STATS_EN
        , .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endfunction

    function automatic logic [31:0] init_word(input int i);
        return 32'(i) * 32'h9E37_79B1;
    endfunction

    // Behavioural macro: both ports read-before-write, data on the pins one cycle after issue
    initial begin
        logic [31:0] smem [256];
        logic        cen_s;
        logic [3:0]  we_s [2];
        logic [7:0]  ad_s [2];
        logic [31:0] wd_s [2];
        for (int i = 0; i < 256; i++) smem[i] = init_word(i);
        sram_rdata0 = '0;
        sram_rdata1 = '0;
        forever begin
            @(negedge clk);
            cen_s = sram_cen;
            we_s[0] = sram_wea0; ad_s[0] = sram_addr0; wd_s[0] = sram_wdata0;
            we_s[1] = sram_wea1; ad_s[1] = sram_addr1; wd_s[1] = sram_wdata1;
            @(posedge clk);
            if (!cen_s) begin
                sram_rdata0 <= smem[ad_s[0]];
                sram_rdata1 <= smem[ad_s[1]];
                for (int p = 0; p < 2; p++)
                    for (int b = 0; b < 4; b++)
                        if (we_s[p][b]) smem[ad_s[p]][8*b +: 8] = wd_s[p][8*b +: 8];
            end
        end
    end

    // Reference model at request level: memory contents, outstanding reads, stats
    typedef struct {
        logic [31:0] data;
        int          t;
    } exp_t;

    exp_t        q [2][$];
    logic [31:0] ref_mem [256];
    logic [31:0] got1 [$];
    logic [31:0] last_rsp [2];
    int          cyc = 0;
    int          rsp_cnt [2];
    int          acc_cyc [2];
    int          acc_cnt [2];
    int          last_rsp_cyc [2];
    int          st_rd = 0, st_wr = 0, st_stall = 0;

    initial begin
        logic        v [2], r [2], f [2], wr [2], rv [2], rr [2], ev, exp_r [2];
        logic [7:0]  a [2], sa [2];
        logic [3:0]  s [2], wea [2];
        logic [31:0] d [2], rd [2], sw [2];
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        for (int c = 0; c < 2; c++) begin
            rsp_cnt[c] = 0; acc_cyc[c] = 0; acc_cnt[c] = 0; last_rsp_cyc[c] = 0; last_rsp[c] = '0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            v[0] = c0_req_valid; r[0] = c0_req_ready; a[0] = c0_req_addr; s[0] = c0_req_wstrb; d[0] = c0_req_wdata;
            v[1] = c1_req_valid; r[1] = c1_req_ready; a[1] = c1_req_addr; s[1] = c1_req_wstrb; d[1] = c1_req_wdata;
            rv[0] = c0_rsp_valid; rr[0] = c0_rsp_ready; rd[0] = c0_rsp_rdata;
            rv[1] = c1_rsp_valid; rr[1] = c1_rsp_ready; rd[1] = c1_rsp_rdata;
            wea[0] = sram_wea0; sa[0] = sram_addr0; sw[0] = sram_wdata0;
            wea[1] = sram_wea1; sa[1] = sram_addr1; sw[1] = sram_wdata1;
            if (!rst_n) begin
                q[0].delete(); q[1].delete();
                st_rd = 0; st_wr = 0; st_stall = 0;
                chk("rst_req_ready0", {31'b0, r[0]}, 0);
                chk("rst_req_ready1", {31'b0, r[1]}, 0);
                chk("rst_rsp_valid0", {31'b0, rv[0]}, 0);
                chk("rst_rsp_valid1", {31'b0, rv[1]}, 0);
                chk("rst_cen", {31'b0, sram_cen}, 1);
                chk("rst_wea", {24'b0, wea[1], wea[0]}, 0);
            end else begin
                for (int c = 0; c < 2; c++) wr[c] = (s[c] != 4'h0);
                exp_r[0] = wr[0] || (q[0].size() < DEPTH);
                exp_r[1] = (wr[1] || (q[1].size() < DEPTH)) && !(v[0] && wr[0] && wr[1] && a[0] == a[1]);
                chk("req_ready0", {31'b0, r[0]}, {31'b0, exp_r[0]});
                chk("req_ready1", {31'b0, r[1]}, {31'b0, exp_r[1]});
                for (int c = 0; c < 2; c++) f[c] = v[c] && r[c];
                chk("sram_cen", {31'b0, sram_cen}, {31'b0, !(f[0] || f[1])});
                for (int c = 0; c < 2; c++) begin
                    chk($sformatf("sram_wea%0d", c), {28'b0, wea[c]}, f[c] ? {28'b0, s[c]} : 32'h0);
                    if (f[c]) chk($sformatf("sram_addr%0d", c), {24'b0, sa[c]}, {24'b0, a[c]});
                    if (f[c] && wr[c]) chk($sformatf("sram_wdata%0d", c), sw[c], d[c]);
                end
                for (int c = 0; c < 2; c++) begin
                    ev = (q[c].size() > 0) && (cyc >= q[c][0].t + 2);
                    chk($sformatf("rsp_valid%0d", c), {31'b0, rv[c]}, {31'b0, ev});
                    if (rv[c] && q[c].size() > 0) begin
                        chk($sformatf("rsp_rdata%0d", c), rd[c], q[c][0].data);
                        if (rr[c]) begin
                            last_rsp[c] = rd[c];
                            last_rsp_cyc[c] = cyc;
                            rsp_cnt[c]++;
                            if (c == 1) got1.push_back(rd[c]);
                            void'(q[c].pop_front());
                        end
                    end
                end
                for (int c = 0; c < 2; c++) begin
                    if (f[c]) begin
                        acc_cyc[c] = cyc;
                        acc_cnt[c]++;
                        if (wr[c]) st_wr++;
                        else begin
                            st_rd++;
                            q[c].push_back('{data: ref_mem[a[c]], t: cyc});
                        end
                    end
                end
                for (int c = 0; c < 2; c++)
                    if (f[c])
                        for (int b = 0; b < 4; b++)
                            if (s[c][b]) ref_mem[a[c]][8*b +: 8] = d[c][8*b +: 8];
                if ((v[0] && !r[0]) || (v[1] && !r[1])) st_stall++;
            end
        end
    end

    task automatic drive(input int ch, input logic vl, input logic [7:0] ad, input logic [3:0] st, input logic [31:0] wd);
        if (ch == 0) begin
            c0_req_valid = vl; c0_req_addr = ad; c0_req_wstrb = st; c0_req_wdata = wd;
        end else begin
            c1_req_valid = vl; c1_req_addr = ad; c1_req_wstrb = st; c1_req_wdata = wd;
        end
    endtask

    task automatic send(input int ch, input logic [7:0] ad, input logic [3:0] st, input logic [31:0] wd);
        logic ok;
        ok = 1'b0;
        drive(ch, 1'b1, ad, st, wd);
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = (ch == 0) ? c0_req_ready : c1_req_ready;
            @(posedge clk); #1;
        end
        drive(ch, 1'b0, ad, st, wd);
        chk($sformatf("accept_c%0d_%02h", ch, ad), {31'b0, ok}, 1);
    endtask

    task automatic wait_rsp(input int ch, input int n_before, input logic [31:0] exp, input string nm);
        for (int i = 0; i < 40 && rsp_cnt[ch] <= n_before; i++) begin
            @(posedge clk); #1;
        end
        chk({nm, "_arrived"}, {31'b0, rsp_cnt[ch] > n_before}, 1);
        chk(nm, last_rsp[ch], exp);
    endtask

`ifdef L1_SRAM_CTRL_STATS_EN
    task automatic chk_stats(input string tag);
        chk({tag, "_stat_rd"}, stat_rd_cnt, st_rd);
        chk({tag, "_stat_wr"}, stat_wr_cnt, st_wr);
        chk({tag, "_stat_stall"}, stat_stall_cnt, st_stall);
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n, a0;
        req_t rq [2];
        logic fired [2];
        rst_n = 1'b0;
        drive(0, 1'b0, 8'h0, 4'h0, 32'h0);
        drive(1, 1'b0, 8'h0, 4'h0, 32'h0);
        c0_rsp_ready = 1'b1;
        c1_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_cen", {31'b0, sram_cen}, 1);
        chk("reset_rsp_valid", {30'b0, c1_rsp_valid, c0_rsp_valid}, 0);
        rst_n = 1'b1;

        // Full write then read back: response visible two cycles after the read issues
        send(0, 8'h10, 4'hF, 32'hDEADBEEF);
        n = rsp_cnt[0];
        send(0, 8'h10, 4'h0, 32'h0);
        a0 = acc_cyc[0];
        wait_rsp(0, n, 32'hDEADBEEF, "rd_0x10");
        chk("rd_latency", last_rsp_cyc[0] - a0, 2);

        send(0, 8'h20, 4'hF, 32'h11223344);
        send(0, 8'h20, 4'h2, 32'h0000AA00);
        n = rsp_cnt[0];
        send(0, 8'h20, 4'h0, 32'h0);
        wait_rsp(0, n, 32'h1122AA44, "partial_wr");

        fork
            send(0, 8'h30, 4'hF, 32'h11111111);
            send(1, 8'h30, 4'h3, 32'h22222222);
        join
        chk("ww_stall_1cyc", acc_cyc[1] - acc_cyc[0], 1);
        n = rsp_cnt[0];
        send(0, 8'h30, 4'h0, 32'h0);
        wait_rsp(0, n, 32'h11112222, "ww_merge");

        send(0, 8'h40, 4'hF, 32'hA5A5A5A5);
        n = rsp_cnt[0];
        fork
            send(0, 8'h40, 4'h0, 32'h0);
            send(1, 8'h40, 4'hF, 32'h5A5A5A5A);
        join
        chk("rw_same_cycle", acc_cyc[0] - acc_cyc[1], 0);
        wait_rsp(0, n, 32'hA5A5A5A5, "rw_old_value");
        n = rsp_cnt[0];
        send(0, 8'h40, 4'h0, 32'h0);
        wait_rsp(0, n, 32'h5A5A5A5A, "rw_new_value");

        // Backpressure: only two reads accepted until responses drain
        c1_rsp_ready = 1'b0;
        got1.delete();
        n = rsp_cnt[1];
        a0 = acc_cnt[1];
        fork
            begin
                send(1, 8'h10, 4'h0, 32'h0);
                send(1, 8'h20, 4'h0, 32'h0);
                send(1, 8'h30, 4'h0, 32'h0);
                send(1, 8'h40, 4'h0, 32'h0);
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                chk("bp_accepts", acc_cnt[1] - a0, 2);
                chk("bp_ready_low", {31'b0, c1_req_ready}, 0);
                c1_rsp_ready = 1'b1;
            end
        join
        for (int i = 0; i < 40 && rsp_cnt[1] < n + 4; i++) begin
            @(posedge clk); #1;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("bp_rsp_count", rsp_cnt[1] - n, 4);
        if (got1.size() == 4) begin
            chk("bp_rsp0", got1[0], 32'hDEADBEEF);
            chk("bp_rsp1", got1[1], 32'h1122AA44);
            chk("bp_rsp2", got1[2], 32'h11112222);
            chk("bp_rsp3", got1[3], 32'h5A5A5A5A);
        end

        // Reset with two queued responses
        c0_rsp_ready = 1'b0;
        send(0, 8'h10, 4'h0, 32'h0);
        send(0, 8'h20, 4'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_valid", {31'b0, c0_rsp_valid}, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_drop_valid", {31'b0, c0_rsp_valid}, 0);
        chk("rst_drop_ready", {31'b0, c0_req_ready}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
`ifdef L1_SRAM_CTRL_STATS_EN
        chk_stats("post_rst");
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_no_stale", {31'b0, c0_rsp_valid}, 0);
        send(0, 8'h30, 4'h0, 32'h0);
        a0 = acc_cyc[0];
        send(0, 8'h20, 4'h0, 32'h0);
        chk("post_rst_credit", acc_cyc[0] - a0, 1);
        n = rsp_cnt[0];
        c0_rsp_ready = 1'b1;
        for (int i = 0; i < 20 && rsp_cnt[0] < n + 2; i++) begin
            @(posedge clk); #1;
        end
        chk("post_rst_drain", rsp_cnt[0] - n, 2);
        chk("post_rst_last", last_rsp[0], 32'h1122AA44);

        // Randomized traffic on a small address window so conflicts are frequent
        fired[0] = 1'b1;
        fired[1] = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < 2; c++) begin
                if (fired[c] || !((c == 0) ? c0_req_valid : c1_req_valid)) begin
                    rq[c].addr  = 8'h80 + 8'($urandom_range(0, 3));
                    rq[c].wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                    rq[c].wdata = $urandom;
                    drive(c, $urandom_range(0, 3) != 0, rq[c].addr, rq[c].wstrb, rq[c].wdata);
                end
            end
            c0_rsp_ready = $urandom_range(0, 3) != 0;
            c1_rsp_ready = $urandom_range(0, 3) != 0;
            @(negedge clk);
            fired[0] = c0_req_valid & c0_req_ready;
            fired[1] = c1_req_valid & c1_req_ready;
            @(posedge clk);
            #1;
        end
        drive(0, 1'b0, 8'h0, 4'h0, 32'h0);
        drive(1, 1'b0, 8'h0, 4'h0, 32'h0);
        c0_rsp_ready = 1'b1;
        c1_rsp_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("drain_q0", q[0].size(), 0);
        chk("drain_q1", q[1].size(), 0);
`ifdef L1_SRAM_CTRL_STATS_EN
        chk_stats("final");
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
